// File: rtl/mdu_iter_pkg.sv
// Shared types and op decode helpers for the iterative multiply/divide unit.
package mdu_iter_pkg;

    localparam int MDUOP_W = 4;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_e;

    typedef struct packed {
        logic    word;
        mdu_op_e op;
    } mduop_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } mdu_state_e;

    function automatic logic op1_signed(input mdu_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic op2_signed(input mdu_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_rem(input mdu_op_e op);
        return op inside {OP_REM, OP_REMU};
    endfunction

endpackage

// File: rtl/mdu_divstep.sv
// One restoring-divide iteration: shift in the next dividend bit, trial subtract.
module mdu_divstep #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rem,
    input  logic            dividend_msb,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic            q_bit
);

    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff;

    assign shifted  = {rem, dividend_msb};
    assign diff     = shifted[XLEN-1:0] - divisor;
    assign q_bit    = (shifted >= {1'b0, divisor});
    assign rem_next = q_bit ? diff : shifted[XLEN-1:0];

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV64M multiply/divide: shift-add multiply, restoring divide,
// valid/ready on both sides, FSM IDLE -> CALC -> DONE.
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter bit FAST_ZERO = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush_i_mdu,
    input  logic               valid_i_mdu,
    output logic               ready_o_mdu,
    input  logic [MDUOP_W-1:0] mduop_i_mdu,
    input  logic [XLEN-1:0]    op1_i_mdu,
    input  logic [XLEN-1:0]    op2_i_mdu,
    output logic               valid_o_mdu,
    input  logic               ready_i_mdu,
    output logic [XLEN-1:0]    result_o_mdu
);

    localparam int CW  = $clog2(XLEN) + 1;
    localparam int WSH = XLEN - 32;

    mdu_state_e      state_q;
    logic [CW-1:0]   cnt_q;
    mdu_op_e         op_q;
    logic            word_q;
    logic            neg_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN:0]   acc_q;
    logic [XLEN-1:0] mpl_q;
    logic [XLEN-1:0] res_q;
    logic            valid_q;
    logic            ready_q;

    mduop_t          req;
    logic            req_w;
    logic [XLEN-1:0] lo1_sx;
    logic [XLEN-1:0] x1;
    logic [XLEN-1:0] x2;
    logic [XLEN-1:0] abs1;
    logic [XLEN-1:0] abs2;
    logic [XLEN-1:0] min_v;
    logic            neg1;
    logic            neg2;
    logic            is_mul_r;
    logic            illegal_r;
    logic            mulz_r;
    logic            divz_r;
    logic            ovf_r;
    logic [XLEN-1:0] fast_res;

    assign req   = mduop_t'(mduop_i_mdu);
    assign req_w = req.word && (XLEN == 64);

    // Operand conditioning at accept: W extension, magnitudes, special cases.
    always_comb begin
        lo1_sx = XLEN'($signed(op1_i_mdu[31:0]));
        x1     = op1_i_mdu;
        x2     = op2_i_mdu;
        min_v  = {1'b1, {(XLEN-1){1'b0}}};
        if (req_w) begin
            x1    = op1_signed(req.op) ? lo1_sx
                                       : XLEN'(op1_i_mdu[31:0]);
            x2    = op2_signed(req.op) ? XLEN'($signed(op2_i_mdu[31:0]))
                                       : XLEN'(op2_i_mdu[31:0]);
            min_v = XLEN'($signed(32'h8000_0000));
        end
        neg1      = op1_signed(req.op) && x1[XLEN-1];
        neg2      = op2_signed(req.op) && x2[XLEN-1];
        abs1      = neg1 ? -x1 : x1;
        abs2      = neg2 ? -x2 : x2;
        is_mul_r  = !req.op[2];
        illegal_r = req_w && is_mul_r && (req.op != OP_MUL);
        mulz_r    = is_mul_r && ((x1 == '0) || (x2 == '0));
        divz_r    = !is_mul_r && (x2 == '0);
        ovf_r     = !is_mul_r && op2_signed(req.op)
                    && (x2 == '1) && (x1 == min_v);
        fast_res  = '0;
        if (divz_r)
            fast_res = is_rem(req.op) ? (req_w ? lo1_sx : op1_i_mdu) : '1;
        else if (ovf_r)
            fast_res = is_rem(req.op) ? '0 : x1;
    end

    logic [XLEN:0]     sum;
    logic [XLEN:0]     acc_n;
    logic [XLEN-1:0]   mpl_n;
    logic [XLEN-1:0]   rem_n;
    logic              q_bit;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   dval;
    logic [XLEN-1:0]   dval_s;
    logic [XLEN-1:0]   fix_res;

    mdu_divstep #(
        .XLEN(XLEN)
    ) u_divstep (
        .rem         (acc_q[XLEN-1:0]),
        .dividend_msb(mpl_q[XLEN-1]),
        .divisor     (a_q),
        .rem_next    (rem_n),
        .q_bit       (q_bit)
    );

    always_comb begin
        sum = acc_q + (mpl_q[0] ? {1'b0, a_q} : '0);
        if (op_q[2]) begin
            acc_n = {1'b0, rem_n};
            mpl_n = {mpl_q[XLEN-2:0], q_bit};
        end else begin
            acc_n = {1'b0, sum[XLEN:1]};
            mpl_n = {sum[0], mpl_q[XLEN-1:1]};
        end
    end

    // W multiply runs 32 steps, leaving the low product word in mpl[XLEN-1 -: 32].
    always_comb begin
        prod   = {acc_n[XLEN-1:0], mpl_n};
        prod_s = neg_q ? -prod : prod;
        dval   = is_rem(op_q) ? acc_n[XLEN-1:0] : mpl_n;
        dval_s = neg_q ? -dval : dval;
        if (op_q[2])
            fix_res = word_q ? XLEN'($signed(dval_s[31:0])) : dval_s;
        else if (word_q)
            fix_res = XLEN'($signed(prod_s[XLEN-1 -: 32]));
        else if (op_q == OP_MUL)
            fix_res = prod_s[XLEN-1:0];
        else
            fix_res = prod_s[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_MUL;
            word_q  <= 1'b0;
            neg_q   <= 1'b0;
            a_q     <= '0;
            acc_q   <= '0;
            mpl_q   <= '0;
            res_q   <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else if (flush_i_mdu) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (valid_i_mdu) begin
                        op_q    <= req.op;
                        word_q  <= req_w;
                        cnt_q   <= req_w ? CW'(32) : CW'(XLEN);
                        acc_q   <= '0;
                        ready_q <= 1'b0;
                        if (is_mul_r) begin
                            a_q   <= abs1;
                            mpl_q <= abs2;
                            neg_q <= neg1 ^ neg2;
                        end else begin
                            a_q   <= abs2;
                            mpl_q <= req_w ? (abs1 << WSH) : abs1;
                            neg_q <= is_rem(req.op) ? neg1
                                     : ((neg1 ^ neg2) && (x2 != '0));
                        end
                        if (illegal_r) begin
                            state_q <= ST_DONE;
                            res_q   <= '0;
                            valid_q <= 1'b1;
                        end else if (FAST_ZERO
                                     && (mulz_r || divz_r || ovf_r)) begin
                            state_q <= ST_DONE;
                            res_q   <= fast_res;
                            valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    acc_q <= acc_n;
                    mpl_q <= mpl_n;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= ST_DONE;
                        res_q   <= fix_res;
                        valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (ready_i_mdu) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready_o_mdu  = ready_q;
    assign valid_o_mdu  = valid_q;
    assign result_o_mdu = res_q;

endmodule
